// File: rtl/note_event_scheduler.sv
// Detects released notes on the tracked slots, quantizes each length to sixteenths and queues
// the events in a FWFT FIFO. Define NOTE_EVENT_SCHEDULER_TIMESTAMP_EN to add onset timestamps.
module note_event_scheduler #(
    parameter int NUM_SLOTS  = 5,
    parameter int NOTE_W     = 8,
    parameter int DUR_W      = 30,
    parameter int LEN_W      = 5,
    parameter int FIFO_DEPTH = 8
) (
    input  logic                          clk_camera_in,
    input  logic                          rst_in,
    input  logic                          enable_in,
    input  logic [NUM_SLOTS*NOTE_W-1:0]   notes_in,
    input  logic [NUM_SLOTS*DUR_W-1:0]    durations_in,
    input  logic [23:0]                   cycles_per_sixteenth_in,
    output logic                          event_valid_out,
    input  logic                          event_ready_in,
    output logic [NOTE_W-1:0]             event_note_out,
    output logic [2:0]                    event_slot_out,
    output logic [DUR_W-1:0]              event_dur_out,
    output logic [LEN_W-1:0]              event_len_out,
`ifdef NOTE_EVENT_SCHEDULER_TIMESTAMP_EN
    output logic [31:0]                   event_onset_out,
`endif
    output logic [$clog2(FIFO_DEPTH):0]   fifo_count_out,
    output logic                          overflow_out,
    output logic                          busy_out
);

    localparam int SLOT_W = 3;
    localparam int PTR_W  = $clog2(FIFO_DEPTH);
    localparam int CNT_W  = PTR_W + 1;
    localparam int REM_W  = DUR_W + 1;
    localparam logic [DUR_W-1:0] DUR_MAX = '1;
    localparam logic [LEN_W-1:0] LEN_MAX = '1;

    function automatic logic [DUR_W-1:0] sat_inc(input logic [DUR_W-1:0] d);
        return (d == DUR_MAX) ? d : d + DUR_W'(1);
    endfunction

    function automatic logic [LEN_W-1:0] clamp_len(input logic [LEN_W-1:0] q);
        return (q == '0) ? LEN_W'(1) : q;
    endfunction

    typedef enum logic [1:0] {S_IDLE, S_LOAD, S_SUB, S_PUSH} state_t;
    state_t state, state_nxt;

    logic [NOTE_W-1:0]    prev_note   [NUM_SLOTS];
    logic [DUR_W-1:0]     prev_dur    [NUM_SLOTS];
    logic [NOTE_W-1:0]    cap_note_p0 [NUM_SLOTS];
    logic [DUR_W-1:0]     cap_dur_p0  [NUM_SLOTS];
    logic [NUM_SLOTS-1:0] vld_p0, release_evt, grant_hit, accept;
    logic                 grant_vld;
    logic [SLOT_W-1:0]    grant_idx, rr_ptr, arb_idx;
    logic                 ovf;

    logic [NOTE_W-1:0]    note_p1;
    logic [SLOT_W-1:0]    slot_p1;
    logic [DUR_W-1:0]     dur_p1;
    logic [23:0]          cps_p1;
    logic [REM_W-1:0]     rem_p1;
    logic [LEN_W-1:0]     q_p1;
    logic                 sub_ok, push, pop, fifo_full;

    logic [NOTE_W-1:0]    mem_note [FIFO_DEPTH];
    logic [SLOT_W-1:0]    mem_slot [FIFO_DEPTH];
    logic [DUR_W-1:0]     mem_dur  [FIFO_DEPTH];
    logic [LEN_W-1:0]     mem_len  [FIFO_DEPTH];
    logic [PTR_W-1:0]     wr_ptr, rd_ptr;
    logic [CNT_W-1:0]     count;

`ifdef NOTE_EVENT_SCHEDULER_TIMESTAMP_EN
    logic [31:0] ts_cnt;
    logic [31:0] cap_onset_p0 [NUM_SLOTS];
    logic [31:0] onset_p1;
    logic [31:0] mem_onset [FIFO_DEPTH];

    always_ff @(posedge clk_camera_in) begin
        if (!rst_in) ts_cnt <= '0;
        else         ts_cnt <= ts_cnt + 32'd1;
    end
`endif

    // Stage p0: release detection, capture and pending bits
    always_comb begin
        release_evt = '0;
        grant_hit   = '0;
        accept      = '0;
        for (int i = 0; i < NUM_SLOTS; i++) begin
            release_evt[i] = enable_in && (prev_note[i] != '0) &&
                             (notes_in[i*NOTE_W +: NOTE_W] != prev_note[i]);
            grant_hit[i]   = grant_vld && (grant_idx == SLOT_W'(i));
            accept[i]      = release_evt[i] && (!vld_p0[i] || grant_hit[i]);
        end
    end

    // Lowest offset from rr_ptr wins, so scan offsets from the far end down.
    always_comb begin
        grant_vld = 1'b0;
        grant_idx = '0;
        arb_idx   = '0;
        if (state == S_IDLE) begin
            for (int k = NUM_SLOTS - 1; k >= 0; k--) begin
                arb_idx = SLOT_W'((int'(rr_ptr) + k) % NUM_SLOTS);
                if (vld_p0[arb_idx]) begin
                    grant_vld = 1'b1;
                    grant_idx = arb_idx;
                end
            end
        end
    end

    always_ff @(posedge clk_camera_in) begin
        if (!rst_in) begin
            for (int i = 0; i < NUM_SLOTS; i++) begin
                prev_note[i] <= '0;
                prev_dur[i]  <= '0;
            end
            vld_p0 <= '0;
            rr_ptr <= '0;
            ovf    <= 1'b0;
        end else begin
            for (int i = 0; i < NUM_SLOTS; i++) begin
                prev_note[i] <= notes_in[i*NOTE_W +: NOTE_W];
                prev_dur[i]  <= durations_in[i*DUR_W +: DUR_W];
                if (grant_hit[i])                  vld_p0[i] <= 1'b0;
                if (accept[i])                     vld_p0[i] <= 1'b1;
                if (release_evt[i] && !accept[i])  ovf       <= 1'b1;
            end
            if (grant_vld)
                rr_ptr <= (grant_idx == SLOT_W'(NUM_SLOTS - 1)) ? '0 : grant_idx + SLOT_W'(1);
        end
    end

    always_ff @(posedge clk_camera_in) begin
        for (int i = 0; i < NUM_SLOTS; i++) begin
            if (accept[i]) begin
                cap_note_p0[i] <= prev_note[i];
                cap_dur_p0[i]  <= sat_inc(prev_dur[i]);
`ifdef NOTE_EVENT_SCHEDULER_TIMESTAMP_EN
                cap_onset_p0[i] <= ts_cnt - 32'(sat_inc(prev_dur[i]));
`endif
            end
        end
    end

    // Stage p1: quantizer FSM (repeated subtraction with half-unit rounding bias)
    assign sub_ok = (rem_p1 >= REM_W'(cps_p1)) && (q_p1 != LEN_MAX);

    always_ff @(posedge clk_camera_in) begin
        if (!rst_in) state <= S_IDLE;
        else         state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        push      = 1'b0;
        case (state)
            S_IDLE: if (grant_vld) state_nxt = S_LOAD;
            S_LOAD: state_nxt = (cycles_per_sixteenth_in == '0) ? S_PUSH : S_SUB;
            S_SUB:  if (!sub_ok) state_nxt = S_PUSH;
            S_PUSH: begin
                if (!fifo_full || pop) begin
                    push      = 1'b1;
                    state_nxt = S_IDLE;
                end
            end
            default: state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge clk_camera_in) begin
        case (state)
            S_IDLE: begin
                if (grant_vld) begin
                    note_p1 <= cap_note_p0[grant_idx];
                    dur_p1  <= cap_dur_p0[grant_idx];
                    slot_p1 <= grant_idx;
`ifdef NOTE_EVENT_SCHEDULER_TIMESTAMP_EN
                    onset_p1 <= cap_onset_p0[grant_idx];
`endif
                end
            end
            S_LOAD: begin
                cps_p1 <= cycles_per_sixteenth_in;
                rem_p1 <= REM_W'(dur_p1) + REM_W'(cycles_per_sixteenth_in >> 1);
                q_p1   <= (cycles_per_sixteenth_in == '0) ? LEN_MAX : '0;
            end
            S_SUB: begin
                if (sub_ok) begin
                    rem_p1 <= rem_p1 - REM_W'(cps_p1);
                    q_p1   <= q_p1 + LEN_W'(1);
                end
            end
            default: ;
        endcase
    end

    // Stage p2: FWFT event queue
    assign fifo_full = (count == CNT_W'(FIFO_DEPTH));
    assign pop       = event_valid_out && event_ready_in;

    always_ff @(posedge clk_camera_in) begin
        if (!rst_in) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + PTR_W'(1);
            if (pop)  rd_ptr <= rd_ptr + PTR_W'(1);
            case ({push, pop})
                2'b10:   count <= count + CNT_W'(1);
                2'b01:   count <= count - CNT_W'(1);
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk_camera_in) begin
        if (push) begin
            mem_note[wr_ptr] <= note_p1;
            mem_slot[wr_ptr] <= slot_p1;
            mem_dur[wr_ptr]  <= dur_p1;
            mem_len[wr_ptr]  <= clamp_len(q_p1);
`ifdef NOTE_EVENT_SCHEDULER_TIMESTAMP_EN
            mem_onset[wr_ptr] <= onset_p1;
`endif
        end
    end

    // Payload is masked while empty so the outputs read zero out of reset.
    assign event_valid_out = (count != '0);
    assign event_note_out  = event_valid_out ? mem_note[rd_ptr] : '0;
    assign event_slot_out  = event_valid_out ? mem_slot[rd_ptr] : '0;
    assign event_dur_out   = event_valid_out ? mem_dur[rd_ptr]  : '0;
    assign event_len_out   = event_valid_out ? mem_len[rd_ptr]  : '0;
`ifdef NOTE_EVENT_SCHEDULER_TIMESTAMP_EN
    assign event_onset_out = event_valid_out ? mem_onset[rd_ptr] : '0;
`endif
    assign fifo_count_out  = count;
    assign overflow_out    = ovf;
    assign busy_out        = (state != S_IDLE) || (|vld_p0);

endmodule

// File: tb/tb_note_event_scheduler.sv
// Bench for note_event_scheduler: directed scenarios plus random single releases, scored
// against a queue model built from the release/round-robin/rounded-division rules.
module tb_note_event_scheduler;

    localparam int NS = 5;
    localparam int NW = 8;
    localparam int DW = 30;
    localparam int LW = 5;
    localparam int FD = 8;
    localparam longint DMAX = (64'd1 << DW) - 1;

    typedef logic [NW+3+DW+LW-1:0] ev_t;

    logic clk = 1'b0;
    initial forever #5 clk = ~clk;

    logic                  rst_n, enable, ready;
    logic [NS*NW-1:0]      notes;
    logic [NS*DW-1:0]      durs;
    logic [23:0]           cps;
    logic                  event_valid_out;
    logic [NW-1:0]         event_note_out;
    logic [2:0]            event_slot_out;
    logic [DW-1:0]         event_dur_out;
    logic [LW-1:0]         event_len_out;
    logic [$clog2(FD):0]   fifo_count_out;
    logic                  overflow_out, busy_out;

    note_event_scheduler dut (
        .clk_camera_in           (clk),
        .rst_in                  (rst_n),
        .enable_in               (enable),
        .notes_in                (notes),
        .durations_in            (durs),
        .cycles_per_sixteenth_in (cps),
        .event_valid_out         (event_valid_out),
        .event_ready_in          (ready),
        .event_note_out          (event_note_out),
        .event_slot_out          (event_slot_out),
        .event_dur_out           (event_dur_out),
        .event_len_out           (event_len_out),
        .fifo_count_out          (fifo_count_out),
        .overflow_out            (overflow_out),
        .busy_out                (busy_out)
    );

    logic [NW-1:0] tb_note [NS];
    logic [DW-1:0] tb_dur  [NS];
    int            h_note  [NS];
    longint        h_dur   [NS];

    always_comb begin
        notes = '0;
        durs  = '0;
        for (int i = 0; i < NS; i++) begin
            notes[i*NW +: NW] = tb_note[i];
            durs[i*DW +: DW]  = tb_dur[i];
        end
    end

    int  n_assert = 0;
    int  n_fail   = 0;
    ev_t exp_q[$];
    int  model_rr = 0;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    function automatic int model_q(input longint d, input int c);
        longint v;
        if (c == 0) return 31;
        v = (d + c / 2) / c;
        return (v > 31) ? 31 : int'(v);
    endfunction

    function automatic ev_t model_ev(input int note, input int slot, input longint durf, input int c);
        longint d;
        int     q;
        int     len;
        d   = (durf > DMAX) ? DMAX : durf;
        q   = model_q(d, c);
        len = (q == 0) ? 1 : q;
        return {NW'(note), 3'(slot), DW'(d), LW'(len)};
    endfunction

    task automatic model_release(input int s);
        exp_q.push_back(model_ev(h_note[s], s, h_dur[s], int'(cps)));
        model_rr = (s + 1) % NS;
    endtask

    // Put a note on a slot whose counter will read durf-1 on the next edge.
    task automatic hold(input int s, input int note, input longint durf);
        tb_note[s] = NW'(note);
        tb_dur[s]  = DW'(durf - 1);
        h_note[s]  = note;
        h_dur[s]   = durf;
    endtask

    // Let the held notes register for one edge, then drop all masked slots together.
    task automatic fire(input logic [NS-1:0] mask, input logic en);
        int r0;
        int idx;
        @(negedge clk);
        enable = en;
        for (int s = 0; s < NS; s++) begin
            if (mask[s]) begin
                tb_note[s] = '0;
                tb_dur[s]  = '0;
            end
        end
        r0 = model_rr;
        if (en) begin
            for (int k = 0; k < NS; k++) begin
                idx = (r0 + k) % NS;
                if (mask[idx]) model_release(idx);
            end
        end
    endtask

    task automatic wait_valid(output int lat);
        lat = -1;
        for (int k = 1; k <= 120; k++) begin
            @(negedge clk);
            if (event_valid_out) begin
                lat = k;
                break;
            end
        end
    endtask

    task automatic wait_drain(input string tag);
        for (int k = 0; k < 300; k++) begin
            @(negedge clk);
            if (exp_q.size() == 0 && !busy_out && !event_valid_out) break;
        end
        check(tag, 64'(exp_q.size() == 0 && !busy_out && !event_valid_out && fifo_count_out == 0), 64'd1);
    endtask

    always @(negedge clk) begin
        #1;
        if (event_valid_out && ready) begin
            n_assert++;
            assert (exp_q.size() != 0) else begin
                n_fail++;
                $error("FAIL unexpected_event: observed 0x%0h expected none",
                       {event_note_out, event_slot_out, event_dur_out, event_len_out});
            end
            if (exp_q.size() != 0) begin
                check("event", 64'({event_note_out, event_slot_out, event_dur_out, event_len_out}),
                      64'(exp_q[0]));
                void'(exp_q.pop_front());
            end
        end
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: observed no finish expected finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int     lat;
        int     s, note, c;
        longint d;

        rst_n  = 1'b0;
        enable = 1'b1;
        ready  = 1'b1;
        cps    = 24'd100;
        for (int i = 0; i < NS; i++) begin
            tb_note[i] = '0;
            tb_dur[i]  = '0;
        end
        repeat (3) @(negedge clk);
        check("rst_valid", 64'(event_valid_out), 64'd0);
        check("rst_count", 64'(fifo_count_out), 64'd0);
        check("rst_overflow", 64'(overflow_out), 64'd0);
        check("rst_busy", 64'(busy_out), 64'd0);
        check("rst_fields", 64'({event_note_out, event_slot_out, event_dur_out, event_len_out}), 64'd0);
        rst_n = 1'b1;
        @(negedge clk);

        // Simultaneous releases on 0,1,4 from rr_ptr 0, then 0+3 reveals where rr_ptr landed
        hold(0, 60, 200); hold(1, 62, 300); hold(4, 65, 400);
        fire(5'b10011, 1'b1);
        wait_drain("t4_drain");
        hold(3, 67, 500); hold(0, 69, 600);
        fire(5'b01001, 1'b1);
        wait_drain("t4_rr_drain");

        hold(2, 60, 1000);
        fire(5'b00100, 1'b1);
        wait_valid(lat);
        check("t1_latency", 64'(lat), 64'(5 + 10));
        wait_drain("t1_drain");

        hold(2, 61, 150);
        fire(5'b00100, 1'b1);
        wait_valid(lat);
        check("t2_latency_150", 64'(lat), 64'(5 + 2));
        wait_drain("t2_drain_150");
        hold(0, 62, 10);
        fire(5'b00001, 1'b1);
        wait_valid(lat);
        check("t2_latency_10", 64'(lat), 64'(5 + 0));
        wait_drain("t2_drain_10");

        hold(1, 63, 39_999_999);
        fire(5'b00010, 1'b1);
        wait_valid(lat);
        check("t3_latency_sat", 64'(lat), 64'(5 + 31));
        wait_drain("t3_drain_sat");
        cps = 24'd0;
        hold(3, 64, 500);
        fire(5'b01000, 1'b1);
        wait_drain("t3_drain_cps0");
        cps = 24'd100;
        hold(4, 66, 64'd1 << DW);
        fire(5'b10000, 1'b1);
        wait_drain("dur_saturate_drain");

        // Disabled release is ignored; shadows still track while disabled
        enable = 1'b0;
        hold(1, 70, 250);
        fire(5'b00010, 1'b0);
        repeat (20) @(negedge clk);
        check("disabled_count", 64'(fifo_count_out), 64'd0);
        check("disabled_busy", 64'(busy_out), 64'd0);
        hold(1, 71, 250);
        fire(5'b00010, 1'b1);
        wait_drain("shadow_while_disabled_drain");

        // Same-note retrigger: only the final drop produces an event
        hold(3, 64, 500);
        @(negedge clk);
        hold(3, 64, 1);
        fire(5'b01000, 1'b1);
        wait_drain("retrigger_drain");

        for (int it = 0; it < 12; it++) begin
            s    = int'($urandom_range(0, NS - 1));
            note = int'($urandom_range(1, 127));
            d    = longint'($urandom_range(1, 4000));
            c    = int'($urandom_range(1, 400));
            cps  = 24'(c);
            hold(s, note, d);
            fire(NS'(1) << s, 1'b1);
            wait_valid(lat);
            check("rand_latency", 64'(lat), 64'(5 + model_q(d, c)));
            wait_drain("rand_drain");
        end

        // Backpressure: fill the FIFO, stall one in PUSH, then overflow a pending slot
        cps   = 24'd100;
        ready = 1'b0;
        for (int k = 0; k < 9; k++) begin
            hold(k % NS, 40 + k, 100 + 50 * k);
            fire(NS'(1) << (k % NS), 1'b1);
            repeat (30) @(negedge clk);
        end
        check("t5_count_full", 64'(fifo_count_out), 64'd8);
        check("t5_busy_stall", 64'(busy_out), 64'd1);
        check("t5_no_overflow_yet", 64'(overflow_out), 64'd0);
        hold(2, 90, 300);
        @(negedge clk);
        model_release(2);
        hold(2, 91, 400);
        @(negedge clk);
        tb_note[2] = '0;
        tb_dur[2]  = '0;
        repeat (2) @(negedge clk);
        check("t5_overflow", 64'(overflow_out), 64'd1);
        check("t5_count_hold", 64'(fifo_count_out), 64'd8);
        ready = 1'b1;
        wait_drain("t5_drain");
        check("t5_overflow_sticky", 64'(overflow_out), 64'd1);

        // Reset in the middle of a long quantization
        hold(0, 72, 3000);
        fire(5'b00001, 1'b1);
        repeat (5) @(negedge clk);
        check("t6_busy_before", 64'(busy_out), 64'd1);
        rst_n = 1'b0;
        @(negedge clk);
        exp_q.delete();
        model_rr = 0;
        check("t6_valid", 64'(event_valid_out), 64'd0);
        check("t6_count", 64'(fifo_count_out), 64'd0);
        check("t6_overflow", 64'(overflow_out), 64'd0);
        check("t6_busy", 64'(busy_out), 64'd0);
        check("t6_fields", 64'({event_note_out, event_slot_out, event_dur_out, event_len_out}), 64'd0);
        rst_n = 1'b1;
        repeat (60) @(negedge clk);
        check("t6_no_event_valid", 64'(event_valid_out), 64'd0);
        check("t6_no_event_count", 64'(fifo_count_out), 64'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
